// File: rtl/clk_ratio_meter.sv
// clk_ratio_meter
// Measures a divided clock (sig_in) in cycles of the reference clock (clk_in).
// Reports the rising-to-rising period, the high time, an update strobe, a lock
// flag and a timeout flag.
//
// Optional feature macro: CLK_METER_DUTY_EN
//   defined   -> the high-time counter is built and high_time is reported.
//   undefined -> no high-time counter; high_time is tied to zero.
//
// Handshake / strobe semantics: upd is a one-cycle pulse, and it is the only
// qualifier for period/high_time changing. valid is a level that says the held
// period/high_time came from a measurement taken since the last enable or timeout.
// Nothing back-pressures the meter: there is no ready.
//
// Debug: dbg_state exposes the FSM state (0 IDLE, 1 WAIT_EDGE, 2 MEASURE).
module clk_ratio_meter #(
  parameter int WIDTH      = 16,
  parameter int LOCK_COUNT = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             upd,
  output logic             valid,
  output logic             locked,
  output logic             timeout,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_EDGE = 2'd1,
    ST_MEASURE   = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [3:0]       LOCK_TOP = 4'(LOCK_COUNT - 1);

  // Synchronizer and edge-detect flops.
  logic r_s1;
  logic r_s2;
  logic r_s3;

  // FSM and measurement state.
  state_t           r_state;
  logic             r_armed;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_period;
  logic [3:0]       r_lock_cnt;
  logic             r_upd;
  logic             r_valid;
  logic             r_locked;
  logic             r_timeout;

  // Decoded events.
  logic       w_rise;
  logic       w_in_wait;
  logic       w_in_meas;
  logic       w_start;
  logic       w_meas_rise;
  logic       w_meas_tick;
  logic       w_tmo;
  logic       w_cnt_max;
  logic       w_same;
  logic [3:0] w_lock_next;

  // Two-flop synchronizer plus delay flop; free-running so the edge detector
  // never sees a stale level when the meter is re-enabled.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise    = r_s2 & ~r_s3;
  assign w_in_wait = (r_state == ST_WAIT_EDGE);
  assign w_in_meas = (r_state == ST_MEASURE);
  assign w_cnt_max = (r_cnt == CNT_MAX);

  // WAIT_EDGE throws away the partial period in progress at enable and the
  // first full period after it; the second observed rise opens the first
  // period that is actually reported.
  assign w_start     = en & w_in_wait & r_armed & w_rise;
  assign w_meas_rise = en & w_in_meas & w_rise;
  assign w_meas_tick = en & w_in_meas & ~w_rise & ~w_cnt_max;
  assign w_tmo       = en & w_in_meas & ~w_rise & w_cnt_max;

  // The previous period only counts for locking when it was a real measurement.
  assign w_same      = r_valid & (r_cnt == r_period);
  assign w_lock_next = w_same ? ((r_lock_cnt == LOCK_TOP) ? r_lock_cnt : r_lock_cnt + 4'd1)
                              : 4'd0;

  // Main FSM: period counter, lock tracking and all registered status outputs.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_armed    <= 1'b0;
      r_cnt      <= '0;
      r_period   <= '0;
      r_lock_cnt <= 4'd0;
      r_upd      <= 1'b0;
      r_valid    <= 1'b0;
      r_locked   <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      if (!en) begin
        // Disable wins in every state; period and timeout keep their values.
        r_state    <= ST_IDLE;
        r_armed    <= 1'b0;
        r_cnt      <= '0;
        r_lock_cnt <= 4'd0;
        r_valid    <= 1'b0;
        r_locked   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_WAIT_EDGE;
            r_armed <= 1'b0;
          end
          ST_WAIT_EDGE: begin
            if (w_rise) begin
              if (r_armed) begin
                r_state <= ST_MEASURE;
                r_armed <= 1'b0;
                r_cnt   <= CNT_ONE;
              end else begin
                r_armed <= 1'b1;
              end
            end
          end
          ST_MEASURE: begin
            if (w_rise) begin
              // A rise on the all-ones count is still a measurement.
              r_period   <= r_cnt;
              r_cnt      <= CNT_ONE;
              r_upd      <= 1'b1;
              r_valid    <= 1'b1;
              r_timeout  <= 1'b0;
              r_lock_cnt <= w_lock_next;
              r_locked   <= w_same & (w_lock_next == LOCK_TOP);
            end else if (w_cnt_max) begin
              // No edge for a full counter range: give up and re-acquire.
              r_state    <= ST_WAIT_EDGE;
              r_armed    <= 1'b0;
              r_cnt      <= '0;
              r_lock_cnt <= 4'd0;
              r_valid    <= 1'b0;
              r_locked   <= 1'b0;
              r_timeout  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_armed <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef CLK_METER_DUTY_EN
  logic [WIDTH-1:0] r_hcnt;
  logic [WIDTH-1:0] r_high_time;

  // High-time counter: counts synchronized-high cycles, tracking r_cnt's
  // load/clear points so it can never exceed the period count.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_hcnt      <= '0;
      r_high_time <= '0;
    end else begin
      if (!en) begin
        r_hcnt <= '0;
      end else if (w_start) begin
        r_hcnt <= CNT_ONE;
      end else if (w_meas_rise) begin
        r_high_time <= r_hcnt;
        r_hcnt      <= CNT_ONE;
      end else if (w_meas_tick) begin
        r_hcnt <= r_hcnt + {{(WIDTH-1){1'b0}}, r_s2};
      end else if (w_tmo) begin
        r_hcnt <= '0;
      end
    end
  end

  assign high_time = r_high_time;
`else
  assign high_time = '0;
`endif

  assign period    = r_period;
  assign upd       = r_upd;
  assign valid     = r_valid;
  assign locked    = r_locked;
  assign timeout   = r_timeout;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_clk_ratio_meter.sv
// Directed bench for clk_ratio_meter (WIDTH=8, LOCK_COUNT=2).
// Expected high_time follows CLK_METER_DUTY_EN: the value itself when defined,
// zero otherwise.
module tb_clk_ratio_meter;

  // ---------------- clock / reset / DUT ----------------
  logic       clk;
  logic       rst;
  logic       en;
  logic       sig_in;
  logic [7:0] period;
  logic [7:0] high_time;
  logic       upd;
  logic       valid;
  logic       locked;
  logic       timeout;
  logic [1:0] dbg_state;

  int total = 0;
  int bad   = 0;

  // sig_in generator controls
  int gen_hi   = 4;
  int gen_lo   = 4;
  bit gen_run  = 1'b0;
  int rise_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  clk_ratio_meter #(
    .WIDTH(8),
    .LOCK_COUNT(2)
  ) dut (
    .clk_in    (clk),
    .rst       (rst),
    .en        (en),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .upd       (upd),
    .valid     (valid),
    .locked    (locked),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // Divided-clock source: high for gen_hi cycles, low for gen_lo cycles,
  // changing on the falling edge of clk; settings latch at each period start.
  initial begin
    int h;
    int l;
    sig_in = 1'b0;
    forever begin
      if (gen_run) begin
        h = gen_hi;
        l = gen_lo;
        sig_in = 1'b1;
        rise_cnt++;
        repeat (h) @(negedge clk);
        sig_in = 1'b0;
        repeat (l) @(negedge clk);
      end else begin
        sig_in = 1'b0;
        @(negedge clk);
      end
    end
  end

  // Hard stop in case something blocks outside the bounded waits.
  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard helpers ----------------
  function automatic logic [7:0] hx(input logic [7:0] v);
`ifdef CLK_METER_DUTY_EN
    return v;
`else
    return 8'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Wait for an upd pulse (optionally one carrying a given period).
  task automatic wait_upd(input bit match, input logic [7:0] want, input int budget,
                          output int used, output bit hit);
    used = 0;
    hit  = 1'b0;
    while (!hit && used < budget) begin
      @(posedge clk);
      #1;
      used++;
      if (upd === 1'b1 && (!match || period === want)) hit = 1'b1;
    end
  endtask

  task automatic wait_tmo(input int budget, output bit hit);
    int used;
    used = 0;
    hit  = 1'b0;
    while (!hit && used < budget) begin
      @(posedge clk);
      #1;
      used++;
      if (timeout === 1'b1) hit = 1'b1;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int used;
    bit hit;
    int base;
    int n_upd;

    rst = 1'b1;
    en  = 1'b0;
    #12;
    chk("reset_period",    period,    8'd0);
    chk("reset_high_time", high_time, 8'd0);
    chk("reset_upd",       upd,       1'b0);
    chk("reset_valid",     valid,     1'b0);
    chk("reset_locked",    locked,    1'b0);
    chk("reset_timeout",   timeout,   1'b0);
    chk("reset_state",     dbg_state, 2'd0);

    // Even ratio, 4 high / 4 low, enable from reset.
    @(negedge clk) rst = 1'b0;
    @(negedge clk) en = 1'b1;
    repeat (2) @(negedge clk);
    base    = rise_cnt;
    gen_hi  = 4;
    gen_lo  = 4;
    gen_run = 1'b1;
    wait_upd(1'b0, 8'd0, 80, used, hit);
    chk("even_first_upd",  hit,             1'b1);
    chk("even_edges",      rise_cnt - base, 3);
    chk("even_period",     period,          8'd8);
    chk("even_high_time",  high_time,       hx(8'd4));
    chk("even_valid",      valid,           1'b1);
    chk("even_locked0",    locked,          1'b0);
    chk("even_timeout",    timeout,         1'b0);
    chk("even_state",      dbg_state,       2'd2);
    @(posedge clk);
    #1;
    chk("upd_one_cycle",   upd,             1'b0);
    wait_upd(1'b0, 8'd0, 20, used, hit);
    chk("even_second_upd", hit,             1'b1);
    chk("even_lock",       locked,          1'b1);
    chk("even_period2",    period,          8'd8);
    wait_upd(1'b0, 8'd0, 20, used, hit);
    chk("even_third_upd",  hit,             1'b1);

    // Asynchronous reset in the middle of a measurement.
    @(posedge clk);
    #3;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    chk("rstmid_period",    period,    8'd0);
    chk("rstmid_high_time", high_time, 8'd0);
    chk("rstmid_upd",       upd,       1'b0);
    chk("rstmid_valid",     valid,     1'b0);
    chk("rstmid_locked",    locked,    1'b0);
    chk("rstmid_timeout",   timeout,   1'b0);
    chk("rstmid_state",     dbg_state, 2'd0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    wait_upd(1'b0, 8'd0, 60, used, hit);
    chk("rstmid_upd_again", hit,       1'b1);
    chk("rstmid_period8",   period,    8'd8);
    chk("rstmid_high4",     high_time, hx(8'd4));
    chk("rstmid_nolock",    locked,    1'b0);

    // Odd ratio, 3 high / 4 low.
    gen_hi = 3;
    gen_lo = 4;
    wait_upd(1'b1, 8'd7, 80, used, hit);
    chk("odd_seen",        hit,       1'b1);
    chk("odd_high_time",   high_time, hx(8'd3));
    chk("odd_lock_drop",   locked,    1'b0);
    wait_upd(1'b0, 8'd0, 20, used, hit);
    chk("odd_second",      hit,       1'b1);
    chk("odd_period",      period,    8'd7);
    chk("odd_lock",        locked,    1'b1);

    // Switch to period 10 mid-run.
    gen_hi = 5;
    gen_lo = 5;
    wait_upd(1'b1, 8'd10, 80, used, hit);
    chk("p10_seen",        hit,       1'b1);
    chk("p10_lock_drop",   locked,    1'b0);
    chk("p10_high_time",   high_time, hx(8'd5));
    wait_upd(1'b0, 8'd0, 20, used, hit);
    chk("p10_second",      hit,       1'b1);
    chk("p10_period",      period,    8'd10);
    chk("p10_relock",      locked,    1'b1);

    // Enable gating: en low for 5 cycles while locked.
    @(negedge clk) en = 1'b0;
    @(posedge clk);
    #1;
    chk("enoff_valid",     valid,     1'b0);
    chk("enoff_locked",    locked,    1'b0);
    chk("enoff_state",     dbg_state, 2'd0);
    chk("enoff_period",    period,    8'd10);
    n_upd = int'(upd);
    repeat (4) begin
      @(posedge clk);
      #1;
      n_upd += int'(upd);
    end
    chk("enoff_no_upd",    n_upd,     0);
    @(negedge clk) en = 1'b1;
    wait_upd(1'b0, 8'd0, 60, used, hit);
    chk("enon_upd",        hit,       1'b1);
    chk("enon_discard",    used >= 22, 1'b1);
    chk("enon_period",     period,    8'd10);
    chk("enon_valid",      valid,     1'b1);
    chk("enon_nolock",     locked,    1'b0);
    wait_upd(1'b0, 8'd0, 20, used, hit);
    chk("enon_relock",     locked,    1'b1);

    // Timeout: sig_in held low after lock.
    gen_run = 1'b0;
    wait_tmo(320, hit);
    chk("tmo_seen",        hit,       1'b1);
    chk("tmo_valid",       valid,     1'b0);
    chk("tmo_locked",      locked,    1'b0);
    chk("tmo_period_kept", period,    8'd10);
    chk("tmo_high_kept",   high_time, hx(8'd5));
    chk("tmo_state",       dbg_state, 2'd1);

    // Restart at period 6; timeout clears only at the first new upd.
    gen_hi  = 3;
    gen_lo  = 3;
    gen_run = 1'b1;
    @(posedge clk);
    #1;
    chk("tmo_holds",       timeout,   1'b1);
    wait_upd(1'b0, 8'd0, 60, used, hit);
    chk("p6_upd",          hit,       1'b1);
    chk("p6_timeout_clr",  timeout,   1'b0);
    chk("p6_period",       period,    8'd6);
    chk("p6_high_time",    high_time, hx(8'd3));
    chk("p6_valid",        valid,     1'b1);

    // Rise on the all-ones count is a measurement (period 255).
    gen_hi = 100;
    gen_lo = 155;
    wait_upd(1'b1, 8'd255, 1200, used, hit);
    chk("max_seen",        hit,       1'b1);
    chk("max_high_time",   high_time, hx(8'd100));
    chk("max_timeout",     timeout,   1'b0);
    chk("max_locked",      locked,    1'b0);

    // One cycle longer than the counter range times out.
    gen_lo = 156;
    wait_tmo(1200, hit);
    chk("over_tmo",        hit,       1'b1);
    chk("over_valid",      valid,     1'b0);
    chk("over_period",     period,    8'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
